// File: rtl/debounce_filter.sv
// Debounce filter: the output takes a new input level only after that level has
// been stable for WAIT_CLK consecutive clk cycles behind a SYNC_STAGES-deep input register.
module debounce_filter #(
    parameter int WAIT_CLK    = 10,
    parameter int SYNC_STAGES = 1
) (
    input  logic sig,
    input  logic clk,
    output logic debc_sig,
    input  logic rst
);

    localparam int CNT_W = $clog2(WAIT_CLK + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CLK - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_d;
    logic                   debc_q;
    logic                   debc_d;
    logic                   s_q;

    assign s_q      = sync_q[SYNC_STAGES-1];
    assign debc_sig = debc_q;

    // Stage 0: input synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= sig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Any return of s_q to the accepted level discards the partial count
    always_comb begin
        cnt_d  = cnt;
        debc_d = debc_q;
        if (s_q == debc_q) begin
            cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
            debc_d = s_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    // Stage 1: stability counter and accepted output level
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            debc_q <= 1'b0;
        end else begin
            cnt    <= cnt_d;
            debc_q <= debc_d;
        end
    end

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter (WAIT_CLK=10, SYNC_STAGES=1, 5us clock).
`timescale 1ns/1ps
module tb_debounce_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;
    logic debc_sig;

    int checks = 0;
    int errors = 0;

    debounce_filter #(.WAIT_CLK(10), .SYNC_STAGES(1)) dut (
        .sig      (sig),
        .clk      (clk),
        .debc_sig (debc_sig),
        .rst      (rst)
    );

    always #2500 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle 1ns past it
    task automatic step(input logic s, input logic r);
        sig = s;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rises;
        int rise_at;
        logic prev;
        logic lvl;

        // 1. reset
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_debc", {7'd0, debc_sig}, 8'd0);
        chk("rst_cnt", 8'(dut.cnt), 8'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("idle_debc", {7'd0, debc_sig}, 8'd0);
            chk("idle_cnt", 8'(dut.cnt), 8'd0);
        end

        // 2. bounce: five toggles, two cycles each
        lvl = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            lvl = ~lvl;
            step(lvl, 1'b0);
            chk("bnc_cnt_a", 8'(dut.cnt), lvl ? 8'd0 : 8'd2);
            chk("bnc_debc", {7'd0, debc_sig}, 8'd0);
            step(lvl, 1'b0);
            chk("bnc_cnt_b", 8'(dut.cnt), lvl ? 8'd1 : 8'd0);
            chk("bnc_debc", {7'd0, debc_sig}, 8'd0);
        end
        step(1'b0, 1'b0);
        chk("bnc_tail_cnt", 8'(dut.cnt), 8'd2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("bnc_end_cnt", 8'(dut.cnt), 8'd0);
        chk("bnc_end_debc", {7'd0, debc_sig}, 8'd0);

        // 3. clean rise
        for (int e = 1; e <= 12; e++) begin
            step(1'b1, 1'b0);
            chk("rise_cnt", 8'(dut.cnt), (e >= 2 && e <= 10) ? 8'(e - 1) : 8'd0);
            chk("rise_debc", {7'd0, debc_sig}, (e >= 11) ? 8'd1 : 8'd0);
        end

        // 4. clean fall
        for (int e = 1; e <= 12; e++) begin
            step(1'b0, 1'b0);
            chk("fall_cnt", 8'(dut.cnt), (e >= 2 && e <= 10) ? 8'(e - 1) : 8'd0);
            chk("fall_debc", {7'd0, debc_sig}, (e >= 11) ? 8'd0 : 8'd1);
        end

        // 5. bounce ending high, then held: exactly one rise, at hold edge 11
        rises = 0;
        rise_at = 0;
        prev = debc_sig;
        lvl = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            lvl = ~lvl;
            for (int k = 0; k < 2; k++) begin
                step(lvl, 1'b0);
                if (debc_sig && !prev) rises++;
                prev = debc_sig;
            end
        end
        for (int e = 1; e <= 14; e++) begin
            step(1'b1, 1'b0);
            if (debc_sig && !prev) begin
                rises++;
                rise_at = e;
            end
            prev = debc_sig;
        end
        chk("pb_rises", 8'(rises), 8'd1);
        chk("pb_rise_edge", 8'(rise_at), 8'd11);
        chk("pb_final", {7'd0, debc_sig}, 8'd1);

        // 6. reset mid-count
        for (int e = 1; e <= 12; e++) step(1'b0, 1'b0);
        chk("mr_pre_debc", {7'd0, debc_sig}, 8'd0);
        for (int e = 1; e <= 6; e++) step(1'b1, 1'b0);
        chk("mr_cnt5", 8'(dut.cnt), 8'd5);
        step(1'b1, 1'b1);
        chk("mr_rst_cnt", 8'(dut.cnt), 8'd0);
        chk("mr_rst_debc", {7'd0, debc_sig}, 8'd0);
        for (int e = 1; e <= 11; e++) begin
            step(1'b1, 1'b0);
            chk("mr_debc", {7'd0, debc_sig}, (e == 11) ? 8'd1 : 8'd0);
            if (e == 1) chk("mr_cnt_first", 8'(dut.cnt), 8'd0);
            if (e == 6) chk("mr_cnt_mid", 8'(dut.cnt), 8'd5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
